// File: rtl/bemf_average.sv
// Per-axis BEMF burst averager: accumulates 13-bit ADC samples per axis burst and
// divides by the sample count with a serial restoring divider (rounded to nearest).
module bemf_average #(
    parameter int DATA_W   = 13,
    parameter int CNT_LOG2 = 6
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  sample_valid_i,
    input  logic [1:0]            sample_axis_i,
    input  logic [DATA_W-1:0]     sample_data_i,
    input  logic                  sample_last_i,
    input  logic [1:0]            addr_i,
    output logic [15:0]           data_rd_o,
    output logic [4*DATA_W-1:0]   avg_out_o,
    output logic                  update_o,
    output logic [1:0]            update_axis_o,
    output logic                  busy_o,
    input  logic                  err_clr_i
);

    localparam int ACC_W  = DATA_W + CNT_LOG2;
    localparam int CNT_W  = CNT_LOG2 + 1;
    localparam int REM_W  = CNT_W + 1;
    localparam int ITER_W = $clog2(ACC_W);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(1 << CNT_LOG2);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV,
        ST_WRITE
    } state_t;

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          acc_axis_q, acc_axis_d;
    logic [ACC_W-1:0]    num_q, num_d;
    logic [CNT_W-1:0]    den_q, den_d;
    logic [REM_W-1:0]    rem_q, rem_d;
    logic [ITER_W-1:0]   iter_q, iter_d;
    logic [1:0]          div_axis_q, div_axis_d;
    logic                update_q, update_d;
    logic [1:0]          update_axis_q, update_axis_d;
    logic                axis_err_q, axis_err_d;
    logic                overrun_q, overrun_d;

    logic                axis_chg;
    logic                full;
    logic                accept;
    logic                burst_end;
    logic                load;
    logic                axis_err_set;
    logic                overrun_set;
    logic [ACC_W-1:0]    base_acc;
    logic [CNT_W-1:0]    base_cnt;
    logic [ACC_W-1:0]    sum_w;
    logic [CNT_W-1:0]    n_w;
    logic [REM_W-1:0]    trial;
    logic                trial_ge;
    logic                wr_en;
    logic [DATA_W-1:0]   quo_sat;
    logic [DATA_W-1:0]   rd_avg;

    // A sample for a different axis while a burst is open restarts the burst from empty.
    assign axis_chg  = sample_valid_i && (cnt_q != '0) && (sample_axis_i != acc_axis_q);
    assign burst_end = sample_valid_i && sample_last_i;

    always_comb begin
        base_acc     = axis_chg ? '0 : acc_q;
        base_cnt     = axis_chg ? '0 : cnt_q;
        full         = (base_cnt == CNT_FULL);
        sum_w        = full ? base_acc : base_acc + ACC_W'(sample_data_i);
        n_w          = full ? base_cnt : base_cnt + CNT_W'(1);
        accept       = sample_valid_i && !(full && !sample_last_i);
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        acc_axis_d   = acc_axis_q;
        axis_err_set = 1'b0;
        if (sample_valid_i && (axis_chg || (full && !sample_last_i))) begin
            axis_err_set = 1'b1;
        end
        if (accept) begin
            acc_axis_d = sample_axis_i;
            if (sample_last_i) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum_w;
                cnt_d = n_w;
            end
        end
    end

    // The WRITE cycle still counts as busy, so a burst ending on it is an overrun.
    assign load        = burst_end && accept && (state_q == ST_IDLE);
    assign overrun_set = burst_end && (state_q != ST_IDLE);

    assign trial    = {rem_q[REM_W-2:0], num_q[ACC_W-1]};
    assign trial_ge = (trial >= {1'b0, den_q});
    assign quo_sat  = (|num_q[ACC_W-1:DATA_W]) ? {DATA_W{1'b1}} : num_q[DATA_W-1:0];

    always_comb begin
        state_d       = state_q;
        num_d         = num_q;
        den_d         = den_q;
        rem_d         = rem_q;
        iter_d        = iter_q;
        div_axis_d    = div_axis_q;
        update_d      = 1'b0;
        update_axis_d = 2'd0;
        wr_en         = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (load) begin
                    num_d      = sum_w + ACC_W'(n_w >> 1);
                    den_d      = n_w;
                    rem_d      = '0;
                    iter_d     = '0;
                    div_axis_d = sample_axis_i;
                    state_d    = ST_DIV;
                end
            end
            ST_DIV: begin
                // Quotient bits shift into the dividend register as its bits are consumed.
                rem_d  = trial_ge ? (trial - {1'b0, den_q}) : trial;
                num_d  = {num_q[ACC_W-2:0], trial_ge};
                iter_d = iter_q + ITER_W'(1);
                if (iter_q == ITER_W'(ACC_W - 1)) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                wr_en         = 1'b1;
                update_d      = 1'b1;
                update_axis_d = div_axis_q;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A fresh error on the same edge as a clear keeps the flag set.
    assign axis_err_d = (axis_err_q && !err_clr_i) || axis_err_set;
    assign overrun_d  = (overrun_q && !err_clr_i) || overrun_set;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= ST_IDLE;
            acc_q         <= '0;
            cnt_q         <= '0;
            acc_axis_q    <= '0;
            num_q         <= '0;
            den_q         <= '0;
            rem_q         <= '0;
            iter_q        <= '0;
            div_axis_q    <= '0;
            update_q      <= 1'b0;
            update_axis_q <= '0;
            axis_err_q    <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            acc_axis_q    <= acc_axis_d;
            num_q         <= num_d;
            den_q         <= den_d;
            rem_q         <= rem_d;
            iter_q        <= iter_d;
            div_axis_q    <= div_axis_d;
            update_q      <= update_d;
            update_axis_q <= update_axis_d;
            axis_err_q    <= axis_err_d;
            overrun_q     <= overrun_d;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_avg
        logic [DATA_W-1:0] avg_q;
        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                avg_q <= '0;
            end else if (wr_en && (div_axis_q == 2'(gi))) begin
                avg_q <= quo_sat;
            end
        end
        assign avg_out_o[gi*DATA_W +: DATA_W] = avg_q;
    end

    assign rd_avg        = avg_out_o[int'(addr_i)*DATA_W +: DATA_W];
    assign data_rd_o     = {overrun_q, axis_err_q, {(14-DATA_W){1'b0}}, rd_avg};
    assign update_o      = update_q;
    assign update_axis_o = update_axis_q;
    assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bemf_average.sv
// Bench for bemf_average: burst-level reference model (sample queues, integer division)
// compared every cycle, plus directed scenarios with hand-computed expectations.
module tb_bemf_average;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        sample_valid_i = 1'b0;
    logic [1:0]  sample_axis_i = 2'd0;
    logic [12:0] sample_data_i = 13'd0;
    logic        sample_last_i = 1'b0;
    logic [1:0]  addr_i = 2'd0;
    logic        err_clr_i = 1'b0;
    logic [15:0] data_rd_o;
    logic [51:0] avg_out_o;
    logic        update_o;
    logic [1:0]  update_axis_o;
    logic        busy_o;

    bemf_average #(.DATA_W(13), .CNT_LOG2(6)) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .sample_valid_i(sample_valid_i),
        .sample_axis_i (sample_axis_i),
        .sample_data_i (sample_data_i),
        .sample_last_i (sample_last_i),
        .addr_i        (addr_i),
        .data_rd_o     (data_rd_o),
        .avg_out_o     (avg_out_o),
        .update_o      (update_o),
        .update_axis_o (update_axis_o),
        .busy_o        (busy_o),
        .err_clr_i     (err_clr_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    // Reference model state
    int m_avg [4];
    bit m_axis_err, m_overrun, m_update, m_pend;
    int m_upd_axis, m_pend_cyc, m_pend_q, m_pend_axis, m_cur_axis;
    int m_burst [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors < 40)
                $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // Model: one step per rising edge, using the inputs present before the edge.
    initial begin
        bit busy_now;
        int sum, n, q;
        forever begin
            @(posedge clk);
            cyc++;
            if (reset_i) begin
                for (int k = 0; k < 4; k++) m_avg[k] = 0;
                m_axis_err = 0; m_overrun = 0; m_update = 0; m_upd_axis = 0;
                m_pend = 0; m_cur_axis = 0;
                m_burst.delete();
            end else begin
                busy_now = m_pend;
                m_update = 0;
                m_upd_axis = 0;
                if (err_clr_i) begin
                    m_axis_err = 0;
                    m_overrun = 0;
                end
                if (m_pend && m_pend_cyc == cyc) begin
                    m_avg[m_pend_axis] = m_pend_q;
                    m_update = 1;
                    m_upd_axis = m_pend_axis;
                    m_pend = 0;
                end
                if (sample_valid_i) begin
                    if (m_burst.size() > 0 && int'(sample_axis_i) != m_cur_axis) begin
                        m_axis_err = 1;
                        m_burst.delete();
                    end
                    if (m_burst.size() == 64 && !sample_last_i) begin
                        m_axis_err = 1;
                    end else begin
                        if (m_burst.size() < 64) m_burst.push_back(int'(sample_data_i));
                        m_cur_axis = int'(sample_axis_i);
                        if (sample_last_i) begin
                            sum = 0;
                            foreach (m_burst[k]) sum += m_burst[k];
                            n = m_burst.size();
                            q = (sum + n / 2) / n;
                            if (q > 8191) q = 8191;
                            if (busy_now) begin
                                m_overrun = 1;
                            end else begin
                                m_pend = 1;
                                m_pend_cyc = cyc + 20;
                                m_pend_q = q;
                                m_pend_axis = int'(sample_axis_i);
                            end
                            m_burst.delete();
                        end
                    end
                end
            end
        end
    end

    // Compare: every falling edge once checking is enabled.
    initial begin
        logic [51:0] exp_avg;
        logic [12:0] exp_rd;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int k = 0; k < 4; k++) exp_avg[k*13 +: 13] = m_avg[k][12:0];
                exp_rd = m_avg[addr_i][12:0];
                check("busy", busy_o, m_pend);
                check("update", update_o, m_update);
                if (m_update) check("update_axis", update_axis_o, m_upd_axis);
                check("avg_out", avg_out_o, exp_avg);
                check("data_rd", data_rd_o, {m_overrun, m_axis_err, 1'b0, exp_rd});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        sample_valid_i = 1'b0;
        sample_last_i  = 1'b0;
        err_clr_i      = 1'b0;
    endtask

    task automatic send(input int axis, input int data, input bit last);
        sample_valid_i = 1'b1;
        sample_axis_i  = axis[1:0];
        sample_data_i  = data[12:0];
        sample_last_i  = last;
        tick();
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_update(input int t0, output int lat, output int uax);
        lat = -1;
        uax = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (update_o === 1'b1) begin
                lat = cyc - t0;
                uax = int'(update_axis_o);
                break;
            end
        end
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL wait_update timeout cyc=%0d actual=no_update required=update", cyc);
        end
        @(posedge clk);
        #2;
    endtask

    initial begin
        int t0, lat, uax, nupd, axis, len, data;

        reset_i = 1'b1;
        idle(3);
        reset_i = 1'b0;
        chk_en  = 1'b1;
        check("reset_avg", avg_out_o, 64'd0);
        check("reset_busy", busy_o, 64'd0);
        check("reset_rd", data_rd_o, 64'd0);

        // Axis 0, 8 x 0x1000
        for (int i = 0; i < 8; i++) send(0, 'h1000, i == 7);
        t0 = cyc;
        wait_update(t0, lat, uax);
        check("t1_latency", lat, 64'd20);
        check("t1_upd_axis", uax, 64'd0);
        check("t1_avg0", avg_out_o[12:0], 64'h1000);

        // Axis 2: 1,2,2 -> (5+1)/3 = 2
        send(2, 1, 0); send(2, 2, 0); send(2, 2, 1);
        t0 = cyc;
        wait_update(t0, lat, uax);
        check("t2_upd_axis", uax, 64'd2);
        check("t2_avg2", avg_out_o[38:26], 64'd2);
        addr_i = 2'd2;
        @(negedge clk);
        check("t2_rd", data_rd_o, 64'h0002);
        tick();

        // Axis 1 burst, then axis 3 burst 5 cycles later while busy
        send(1, 100, 0); send(1, 200, 0); send(1, 300, 0); send(1, 400, 1);
        t0 = cyc;
        idle(4);
        send(3, 'h1FFF, 1);
        check("t3_overrun", data_rd_o[15], 64'd1);
        wait_update(t0, lat, uax);
        check("t3_latency", lat, 64'd20);
        check("t3_upd_axis", uax, 64'd1);
        check("t3_avg1", avg_out_o[25:13], 64'd250);
        check("t3_avg3", avg_out_o[51:39], 64'd0);
        err_clr_i = 1'b1;
        tick();
        check("t3_clr", data_rd_o[15], 64'd0);

        // Axis switch mid-burst
        send(0, 7, 0); send(0, 7, 0); send(1, 10, 0);
        check("t4_axiserr", data_rd_o[14], 64'd1);
        send(1, 20, 1);
        t0 = cyc;
        wait_update(t0, lat, uax);
        check("t4_avg1", avg_out_o[25:13], 64'd15);
        err_clr_i = 1'b1;
        tick();

        // 64 full-scale samples, then overfill
        for (int i = 0; i < 64; i++) send(3, 'h1FFF, i == 63);
        t0 = cyc;
        wait_update(t0, lat, uax);
        check("t5_avg3", avg_out_o[51:39], 64'h1FFF);
        for (int i = 0; i < 64; i++) send(3, 'h1FFF, 0);
        check("t5_noerr64", data_rd_o[14], 64'd0);
        send(3, 'h1FFF, 0);
        check("t5_err65", data_rd_o[14], 64'd1);
        send(0, 5, 1);
        t0 = cyc;
        wait_update(t0, lat, uax);
        err_clr_i = 1'b1;
        tick();

        // Reset 5 cycles into a division
        send(2, 100, 1);
        idle(4);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        check("t6_busy", busy_o, 64'd0);
        check("t6_avg", avg_out_o, 64'd0);
        nupd = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (update_o !== 1'b0) nupd++;
        end
        check("t6_noupdate", nupd, 64'd0);
        tick();

        // Randomized bursts
        for (int b = 0; b < 60; b++) begin
            axis   = $urandom_range(0, 3);
            len    = $urandom_range(1, 12);
            addr_i = 2'($urandom_range(0, 3));
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 19) == 0) axis = $urandom_range(0, 3);
                data = ($urandom_range(0, 3) == 0) ? 8191 : $urandom_range(0, 8191);
                if ($urandom_range(0, 9) == 0) err_clr_i = 1'b1;
                send(axis, data, i == len - 1);
                if ($urandom_range(0, 4) == 0) begin
                    sample_last_i = ($urandom_range(0, 1) == 1);
                    tick();
                end
            end
            repeat ($urandom_range(0, 25)) begin
                sample_last_i = ($urandom_range(0, 3) == 0);
                tick();
            end
        end
        idle(30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
